fxp_eval_sched: RTL

Two-requester scheduler for the fixed-point `y = x^2 + x` datapath. It arbitrates round-robin between two sample sources using valid/ready handshakes and drives the datapath enable and operand. It captures the datapath result one cycle after issue, then reduces it to a requester-facing Q format with a requester ID. It sits between the sample producers and the datapath, which it shares as a single non-pipelined resource.

---
 rtl/fxp_sched_pkg.sv | 15 +
 rtl/fxp_narrow.sv | 43 ++++
 rtl/fxp_eval_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fxp_sched_pkg.sv
// Shared types and constants for the fxp_eval_sched scheduler and its helpers.
package fxp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef logic req_id_t;

  localparam int DONE_W = 16;

endpackage

// File: rtl/fxp_narrow.sv
// Combinational signed Q-format reduction: floor the fraction, then narrow the integer part.
// FXP_SCHED_SAT_EN selects saturating integer narrowing; otherwise the low integer bits are kept.
module fxp_narrow #(
  parameter int WI_IN  = 17,
  parameter int WF_IN  = 16,
  parameter int WI_OUT = 8,
  parameter int WF_OUT = 8
) (
  input  logic [WI_IN+WF_IN-1:0]   a,
  output logic [WI_OUT+WF_OUT-1:0] y
);

  localparam int WA = WI_IN + WF_IN;
  localparam int WY = WI_OUT + WF_OUT;

  logic [WF_OUT-1:0] frac;
  logic [WI_OUT-1:0] int_wrap;
  logic              unused_bits;

  // Dropping the low fraction bits of a two's complement value rounds toward -inf.
  assign frac        = a[WF_IN-1 -: WF_OUT];
  assign int_wrap    = a[WF_IN +: WI_OUT];
  assign unused_bits = ^a;

`ifdef FXP_SCHED_SAT_EN
  logic [WA-WF_IN-WI_OUT:0] top_bits;
  logic                     fits;

  // The value fits when every bit from the new sign position upward agrees.
  assign top_bits = a[WA-1:WF_IN+WI_OUT-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_comb begin
    y = {int_wrap, frac};
    if (!fits) begin
      y = a[WA-1] ? {1'b1, {(WY-1){1'b0}}} : {1'b0, {(WY-1){1'b1}}};
    end
  end
`else
  assign y = {int_wrap, frac};
`endif

endmodule

// File: rtl/fxp_eval_sched.sv
// Round-robin two-requester scheduler for the shared non-pipelined y = x^2 + x datapath.
// Build option FXP_SCHED_SAT_EN makes the result narrowing saturate instead of wrap.
module fxp_eval_sched
  import fxp_sched_pkg::*;
#(
  parameter int WI_in  = 8,
  parameter int WF_in  = 8,
  parameter int WI_out = 17,
  parameter int WF_out = 16,
  parameter int WI_res = 8,
  parameter int WF_res = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [WI_in+WF_in-1:0]   req0_x,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [WI_in+WF_in-1:0]   req1_x,
  output logic                     dp_en,
  output logic [WI_in+WF_in-1:0]   dp_x,
  input  logic [WI_out+WF_out-1:0] dp_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_id,
  output logic [WI_res+WF_res-1:0] res_y,
  output logic [15:0]              done_cnt
);

  localparam int WX = WI_in + WF_in;
  localparam int WR = WI_res + WF_res;

  state_t              state_q, state_d;
  logic                pri_q, pri_d;
  logic [WX-1:0]       x_q, x_d;
  req_id_t             id_q, id_d;
  logic [WR-1:0]       res_y_q, res_y_d;
  logic                res_valid_q, res_valid_d;
  logic                dp_en_q, dp_en_d;
  logic [DONE_W-1:0]   done_q, done_d;

  logic [WR-1:0]       narrow_y;
  req_id_t             win;
  logic                grant;

  fxp_narrow #(
    .WI_IN (WI_out),
    .WF_IN (WF_out),
    .WI_OUT(WI_res),
    .WF_OUT(WF_res)
  ) u_narrow (
    .a(dp_y),
    .y(narrow_y)
  );

  always_comb begin
    win         = (req0_valid & req1_valid) ? pri_q : req1_valid;
    // Gated by RST so the handshake outputs read 0 while reset is held.
    grant       = (state_q == IDLE) & (req0_valid | req1_valid) & ~RST;
    state_d     = state_q;
    pri_d       = pri_q;
    x_d         = x_q;
    id_d        = id_q;
    res_y_d     = res_y_q;
    res_valid_d = 1'b0;
    dp_en_d     = 1'b0;
    done_d      = done_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          x_d     = win ? req1_x : req0_x;
          id_d    = win;
          pri_d   = ~win;
          dp_en_d = 1'b1;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        state_d     = OUT;
        res_y_d     = narrow_y;
        res_valid_d = 1'b1;
      end
      OUT: begin
        res_valid_d = 1'b1;
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          done_d      = done_q + DONE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      pri_q       <= 1'b0;
      x_q         <= '0;
      id_q        <= 1'b0;
      res_y_q     <= '0;
      res_valid_q <= 1'b0;
      dp_en_q     <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      pri_q       <= pri_d;
      x_q         <= x_d;
      id_q        <= id_d;
      res_y_q     <= res_y_d;
      res_valid_q <= res_valid_d;
      dp_en_q     <= dp_en_d;
      done_q      <= done_d;
    end
  end

  assign req0_ready = grant & ~win;
  assign req1_ready = grant & win;
  assign dp_en      = dp_en_q;
  assign dp_x       = x_q;
  assign res_valid  = res_valid_q;
  assign res_id     = id_q;
  assign res_y      = res_y_q;
  assign done_cnt   = done_q;

endmodule
